m_imem_loader: RTL and testbench

Serial program loader that fills the processor's 4K-word memory over a UART line. It receives 8N1 bytes, assembles a length header and big-endian 32-bit words, and writes them one per cycle through the same address/write-enable/data port the memory already exposes. It also holds the processor in reset until the image is complete. It sits between the board's RX pin and the write side of `m_memory`; the processor reads the memory contents once `r_busy` drops.

---
 rtl/m_imem_loader.sv | 229 ++++++++++++++++++++++
 tb/tb_m_imem_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_imem_loader.sv
// m_imem_loader: UART (8N1) program loader for the 4K-word instruction memory.
// Receives a 16-bit big-endian word count followed by big-endian 32-bit words
// and writes each word through the memory's address/write-enable/data port.
// The processor is held in reset (r_busy) until the whole image has been written.
module m_imem_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_rxd,
  output logic [11:0] r_addr,
  output logic        r_we,
  output logic [31:0] r_din,
  output logic        r_busy,
  output logic        r_done,
  output logic        r_err
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    L_LEN   = 3'd0,
    L_DATA  = 3'd1,
    L_WRITE = 3'd2,
    L_DONE  = 3'd3,
    L_ERR   = 3'd4
  } ld_state_t;

  logic            sync1_q;
  logic            sync2_q;
  logic            rx_prev_q;
  logic            rx_s;

  rx_state_t       rx_state_q;
  logic [CW-1:0]   bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            byte_v_q;
  logic [7:0]      rx_byte_q;
  logic            frm_err_q;

  ld_state_t       ld_state_q;
  logic [7:0]      len_hi_q;
  logic [1:0]      byte_cnt_q;
  logic [15:0]     rem_q;
  logic [15:0]     hdr_s;

  assign rx_s  = sync2_q;
  assign hdr_s = {len_hi_q, rx_byte_q};

  // Two-flop synchronizer for the asynchronous RX pin plus a delayed copy for edge detection.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= w_rxd;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // UART receive FSM: start-bit qualification at mid-bit, 8 data samples LSB first, stop check.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      rx_state_q <= RX_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_v_q   <= 1'b0;
      rx_byte_q  <= 8'h00;
      frm_err_q  <= 1'b0;
    end else begin
      byte_v_q  <= 1'b0;
      frm_err_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            rx_state_q <= RX_START;
            bit_cnt_q  <= HALF_M1;
          end else begin
            rx_state_q <= RX_IDLE;
          end
        end
        RX_START: begin
          if (bit_cnt_q == '0) begin
            if (!rx_s) begin
              rx_state_q <= RX_DATA;
              bit_cnt_q  <= FULL_M1;
              bit_idx_q  <= 3'd0;
            end else begin
              rx_state_q <= RX_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        RX_DATA: begin
          if (bit_cnt_q == '0) begin
            shift_q   <= {rx_s, shift_q[7:1]};
            bit_cnt_q <= FULL_M1;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_state_q <= RX_DATA;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        RX_STOP: begin
          if (bit_cnt_q == '0) begin
            if (rx_s) begin
              byte_v_q  <= 1'b1;
              rx_byte_q <= shift_q;
            end else begin
              frm_err_q <= 1'b1;
            end
            rx_state_q <= RX_IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        default: begin
          rx_state_q <= RX_IDLE;
        end
      endcase
    end
  end

  // Load FSM: header collection, word assembly, one-cycle memory write, terminal done/error.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      ld_state_q <= L_LEN;
      len_hi_q   <= 8'h00;
      byte_cnt_q <= 2'd0;
      rem_q      <= 16'h0000;
      r_addr     <= 12'h000;
      r_we       <= 1'b0;
      r_din      <= 32'h0000_0000;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (ld_state_q)
        L_LEN: begin
          if (frm_err_q) begin
            ld_state_q <= L_ERR;
            r_err      <= 1'b1;
          end else if (byte_v_q) begin
            if (byte_cnt_q == 2'd0) begin
              len_hi_q   <= rx_byte_q;
              byte_cnt_q <= 2'd1;
            end else begin
              byte_cnt_q <= 2'd0;
              if (hdr_s == 16'h0000) begin
                ld_state_q <= L_DONE;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                rem_q      <= hdr_s;
                ld_state_q <= L_DATA;
              end
            end
          end else begin
            ld_state_q <= L_LEN;
          end
        end
        L_DATA: begin
          if (frm_err_q) begin
            ld_state_q <= L_ERR;
            r_err      <= 1'b1;
          end else if (byte_v_q) begin
            r_din <= {r_din[23:0], rx_byte_q};
            if (byte_cnt_q == 2'd3) begin
              byte_cnt_q <= 2'd0;
              r_we       <= 1'b1;
              ld_state_q <= L_WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end else begin
            ld_state_q <= L_DATA;
          end
        end
        L_WRITE: begin
          // The write happens during this cycle; advance to the next slot afterwards.
          r_we   <= 1'b0;
          r_addr <= r_addr + 12'd1;
          rem_q  <= rem_q - 16'd1;
          if (frm_err_q) begin
            ld_state_q <= L_ERR;
            r_err      <= 1'b1;
          end else if (rem_q == 16'd1) begin
            ld_state_q <= L_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            ld_state_q <= L_DATA;
          end
        end
        L_DONE: begin
          // Image complete: later bytes and framing errors are deliberately ignored.
          ld_state_q <= L_DONE;
        end
        L_ERR: begin
          r_we       <= 1'b0;
          ld_state_q <= L_ERR;
        end
        default: begin
          ld_state_q <= L_ERR;
          r_err      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m_imem_loader.sv
// Self-checking bench for m_imem_loader at CLKS_PER_BIT = 8.
// Byte images are built in queues; the expected memory writes are derived from
// the byte stream itself (header count, big-endian words, sequential addresses).
module tb_m_imem_loader;

  localparam int CPB = 8;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_rxd = 1'b1;
  logic [11:0] r_addr;
  logic        r_we;
  logic [31:0] r_din;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  m_imem_loader #(.CLKS_PER_BIT(CPB)) dut (
    .w_clk (w_clk),
    .w_rst (w_rst),
    .w_rxd (w_rxd),
    .r_addr(r_addr),
    .r_we  (r_we),
    .r_din (r_din),
    .r_busy(r_busy),
    .r_done(r_done),
    .r_err (r_err)
  );

  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Write monitor: captures every write, checks pulse width and busy/done handover.
  logic [43:0] wq[$];
  int cyc = 0;
  int last_we_cyc = -100;
  int done_cyc = -1;
  logic prev_we = 1'b0;
  logic prev_done = 1'b0;
  logic prev_busy = 1'b1;

  always @(negedge w_clk) begin
    cyc++;
    if (r_we) begin
      chk("we_width", {31'b0, prev_we}, 32'd0);
      wq.push_back({r_addr, r_din});
      last_we_cyc = cyc;
    end
    if (r_done && !prev_done) begin
      done_cyc = cyc;
      chk("busy_low_at_done", {31'b0, r_busy}, 32'd0);
      chk("busy_high_before_done", {31'b0, prev_busy}, 32'd1);
    end
    prev_we   = r_we;
    prev_done = r_done;
    prev_busy = r_busy;
  end

  task automatic drive_bit(input logic v);
    w_rxd = v;
    repeat (CPB) @(posedge w_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(posedge w_clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    w_rxd = 1'b1;
  endtask

  task automatic pulse_reset();
    @(posedge w_clk);
    #1;
    w_rst = 1'b1;
    w_rxd = 1'b1;
    repeat (3) @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    repeat (2) @(posedge w_clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    for (int i = 0; i < limit && !r_done; i++) @(negedge w_clk);
    repeat (3) @(negedge w_clk);
  endtask

  // Sends a complete image and compares the captured writes with those implied by the bytes.
  task automatic do_load(input logic [7:0] bytes[$], input bit with_rst, input string tag);
    int n;
    logic [31:0] w;
    if (with_rst) pulse_reset();
    wq.delete();
    done_cyc = -1;
    last_we_cyc = -100;
    for (int i = 0; i < bytes.size(); i++) send_byte(bytes[i], 1'b1);
    wait_done(40);
    n = {bytes[0], bytes[1]};
    chk({tag, "_nwrites"}, wq.size(), n);
    for (int k = 0; k < n; k++) begin
      w = {bytes[2+4*k], bytes[3+4*k], bytes[4+4*k], bytes[5+4*k]};
      if (k < wq.size()) begin
        chk({tag, "_addr"}, {20'b0, wq[k][43:32]}, k % 4096);
        chk({tag, "_data"}, wq[k][31:0], w);
      end
    end
    chk({tag, "_done"}, {31'b0, r_done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, r_busy}, 32'd0);
    chk({tag, "_err"}, {31'b0, r_err}, 32'd0);
    chk({tag, "_final_addr"}, {20'b0, r_addr}, n % 4096);
    if (n > 0) chk({tag, "_done_after_we"}, done_cyc, last_we_cyc + 1);
  endtask

  initial begin
    logic [7:0] img[$];
    logic [43:0] snap;
    logic [2:0] flags;
    int s, nw;

    // 1. reset values while reset is held
    repeat (3) @(posedge w_clk);
    #1;
    chk("rst_addr", {20'b0, r_addr}, 32'd0);
    chk("rst_we", {31'b0, r_we}, 32'd0);
    chk("rst_din", r_din, 32'd0);
    chk("rst_busy", {31'b0, r_busy}, 32'd1);
    chk("rst_done", {31'b0, r_done}, 32'd0);
    chk("rst_err", {31'b0, r_err}, 32'd0);
    w_rst = 1'b0;

    // 2. two-word load, then a trailing byte and a bad-stop byte after done are ignored
    img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h20, 8'h20, 8'h0A, 8'h00, 8'h01};
    do_load(img, 1'b1, "two_word");
    snap  = {r_addr, r_din};
    flags = {r_busy, r_done, r_err};
    send_byte(8'hFF, 1'b1);
    send_byte(8'h3C, 1'b0);
    repeat (12) @(negedge w_clk);
    chk("post_done_nwrites", wq.size(), 32'd2);
    chk("post_done_addr", {20'b0, r_addr}, {20'b0, snap[43:32]});
    chk("post_done_din", r_din, snap[31:0]);
    chk("post_done_flags", {29'b0, r_busy, r_done, r_err}, {29'b0, flags});
    chk("post_done_err_ignored", {31'b0, r_err}, 32'd0);

    // 3. empty image: done about one byte time after the second header byte starts
    pulse_reset();
    wq.delete();
    done_cyc = -1;
    send_byte(8'h00, 1'b1);
    s = cyc;
    send_byte(8'h00, 1'b1);
    wait_done(40);
    chk("empty_done", {31'b0, r_done}, 32'd1);
    chk("empty_busy", {31'b0, r_busy}, 32'd0);
    chk("empty_nwrites", wq.size(), 32'd0);
    chk("empty_latency_ok", {31'b0, (done_cyc - s >= 76) && (done_cyc - s <= 86)}, 32'd1);

    // 4. start-bit glitch, then a normal one-word load without reset
    pulse_reset();
    @(posedge w_clk);
    #1;
    w_rxd = 1'b0;
    repeat (2) @(posedge w_clk);
    #1;
    w_rxd = 1'b1;
    repeat (40) @(posedge w_clk);
    #1;
    img = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11};
    do_load(img, 1'b0, "glitch");

    // 5. framing error in the data phase
    pulse_reset();
    wq.delete();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    s = cyc;
    send_byte(8'h55, 1'b0);
    for (int i = 0; i < 20 && !r_err; i++) @(negedge w_clk);
    chk("ferr_err", {31'b0, r_err}, 32'd1);
    chk("ferr_latency_ok", {31'b0, (cyc - s >= 76) && (cyc - s <= 86)}, 32'd1);
    chk("ferr_busy", {31'b0, r_busy}, 32'd1);
    chk("ferr_done", {31'b0, r_done}, 32'd0);
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 1'b1);
    repeat (10) @(negedge w_clk);
    chk("ferr_nwrites", wq.size(), 32'd0);
    chk("ferr_sticky", {31'b0, r_err}, 32'd1);
    chk("ferr_done_after", {31'b0, r_done}, 32'd0);
    pulse_reset();
    chk("ferr_cleared", {31'b0, r_err}, 32'd0);

    // 6. reset mid-word discards the partial word and restarts at the header
    pulse_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    pulse_reset();
    chk("midrst_addr", {20'b0, r_addr}, 32'd0);
    chk("midrst_din", r_din, 32'd0);
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_load(img, 1'b0, "midrst");

    // 7. randomized images
    for (int it = 0; it < 4; it++) begin
      nw = $urandom_range(1, 3);
      img.delete();
      img.push_back(8'h00);
      img.push_back(8'(nw));
      for (int j = 0; j < 4 * nw; j++) img.push_back(8'($urandom_range(0, 255)));
      do_load(img, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
